// File: rtl/dcm_phase_scheduler_if.sv
// DCM fine phase-shift port: one request/complete handshake between the
// scheduler (master) and the DCM PS interface (slave).
interface dcm_phase_scheduler_if;
  logic psen;
  logic psincdec;
  logic psdone;

  modport master (
    output psen,
    output psincdec,
    input  psdone
  );

  modport slave (
    input  psen,
    input  psincdec,
    output psdone
  );
endinterface

// File: rtl/dcm_phase_scheduler.sv
// DCM phase scheduler for the metastability TRNG: steps the sampling-clock
// phase one increment at a time, measures the sampler bias over a window
// after each step, locks on a balanced phase and re-tunes on loss of balance.
module dcm_phase_scheduler #(
  parameter int unsigned WINDOW         = 256,
  parameter int unsigned TOL            = 16,
  parameter int unsigned SETTLE_CYC     = 64,
  parameter int unsigned MAX_STEPS      = 255,
  parameter int unsigned PSDONE_TIMEOUT = 1023,
  parameter int unsigned RELOCK_MISSES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      metastable_bit,
  dcm_phase_scheduler_if.master     ps,
  output logic                      enable_sampling,
  output logic                      locked,
  output logic                      fault,
  output logic signed [9:0]         phase_pos,
  output logic [$clog2(WINDOW):0]   ones_count
);

  localparam int unsigned CNT_W   = $clog2(WINDOW) + 1;
  localparam int unsigned PH_W    = 10;
  localparam int unsigned HALF    = WINDOW / 2;
  localparam int unsigned MAX_TW  = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int unsigned TMR_MAX = (PSDONE_TIMEOUT > MAX_TW) ? PSDONE_TIMEOUT : MAX_TW;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned MISS_W  = $clog2(RELOCK_MISSES + 1);

  localparam logic signed [PH_W-1:0] POS_LIM = PH_W'(MAX_STEPS);
  localparam logic signed [PH_W-1:0] NEG_LIM = -POS_LIM;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT_DONE,
    S_SETTLE,
    S_MEASURE,
    S_EVAL,
    S_LOCKED,
    S_FAULT
  } state_e;

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [CNT_W-1:0]        acc_q, acc_d;
  logic [MISS_W-1:0]       miss_q, miss_d;
  logic                    dir_q, dir_d;
  logic signed [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0]        ones_q, ones_d;
  logic                    psen_q;
  logic                    en_q;
  logic                    lock_q;
  logic                    fault_q;

  logic [CNT_W-1:0]        acc_inc;
  logic [CNT_W-1:0]        win_cnt;
  logic [31:0]             win_ext;
  logic [31:0]             dev;
  logic                    balanced;
  logic                    at_pos;
  logic                    at_neg;
  logic                    settle_last;
  logic                    window_last;
  logic                    timeout_last;

  // Running ones count including the bit sampled this cycle.
  assign acc_inc = acc_q + CNT_W'(metastable_bit);

  // EVAL judges the finished measurement; LOCKED judges its window in-line.
  assign win_cnt = (state_q == S_EVAL) ? acc_q : acc_inc;

  // Deviation from WINDOW/2 computed on 32-bit values so it never wraps.
  always_comb begin
    win_ext = 32'(win_cnt);
    if (win_ext >= 32'(HALF)) begin
      dev = win_ext - 32'(HALF);
    end else begin
      dev = 32'(HALF) - win_ext;
    end
  end

  assign balanced = (dev <= 32'(TOL));

  // Sweep end points in the current direction.
  assign at_pos = dir_q && (phase_q == POS_LIM);
  assign at_neg = !dir_q && (phase_q == NEG_LIM);

  assign settle_last  = (tmr_q == TMR_W'(SETTLE_CYC - 1));
  assign window_last  = (tmr_q == TMR_W'(WINDOW - 1));
  assign timeout_last = (tmr_q == TMR_W'(PSDONE_TIMEOUT - 1));

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    acc_d   = acc_q;
    miss_d  = miss_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    ones_d  = ones_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        tmr_d   = '0;
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (ps.psdone) begin
          phase_d = dir_q ? (phase_q + PH_W'(1)) : (phase_q - PH_W'(1));
          tmr_d   = '0;
          state_d = S_SETTLE;
        end else if (timeout_last) begin
          state_d = S_FAULT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_SETTLE: begin
        if (settle_last) begin
          tmr_d   = '0;
          acc_d   = '0;
          state_d = S_MEASURE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_MEASURE: begin
        acc_d = acc_inc;
        if (window_last) begin
          tmr_d   = '0;
          state_d = S_EVAL;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_EVAL: begin
        ones_d = acc_q;
        if (balanced) begin
          miss_d  = '0;
          tmr_d   = '0;
          acc_d   = '0;
          state_d = S_LOCKED;
        end else if (at_neg) begin
          state_d = S_FAULT;
        end else begin
          if (at_pos) begin
            dir_d = 1'b0;
          end
          state_d = S_SHIFT;
        end
      end

      S_LOCKED: begin
        if (window_last) begin
          ones_d = acc_inc;
          acc_d  = '0;
          tmr_d  = '0;
          if (balanced) begin
            miss_d = '0;
          end else if (miss_q == MISS_W'(RELOCK_MISSES - 1)) begin
            // Lost balance: resume the sweep from the current position.
            miss_d = '0;
            if (at_neg) begin
              state_d = S_FAULT;
            end else begin
              if (at_pos) begin
                dir_d = 1'b0;
              end
              state_d = S_SHIFT;
            end
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end else begin
          acc_d = acc_inc;
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, sweep direction, phase position and last window result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmr_q   <= '0;
      acc_q   <= '0;
      miss_q  <= '0;
      dir_q   <= 1'b1;
      phase_q <= '0;
      ones_q  <= '0;
    end else begin
      tmr_q   <= tmr_d;
      acc_q   <= acc_d;
      miss_q  <= miss_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      ones_q  <= ones_d;
    end
  end

  // Registered status and strobe outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      psen_q  <= 1'b0;
      en_q    <= 1'b0;
      lock_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      psen_q  <= (state_d == S_SHIFT);
      en_q    <= (state_d == S_LOCKED);
      lock_q  <= (state_d == S_LOCKED);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign ps.psen         = psen_q;
  assign ps.psincdec     = dir_q;
  assign enable_sampling = en_q;
  assign locked          = lock_q;
  assign fault           = fault_q;
  assign phase_pos       = phase_q;
  assign ones_count      = ones_q;

endmodule

// File: tb/tb_dcm_phase_scheduler.sv
// Directed bench for dcm_phase_scheduler: reset, immediate lock, stepping,
// relock, psdone timeout (default instance) and sweep exhaustion (MAX_STEPS=4).
module tb_dcm_phase_scheduler;

  localparam int M_TOG  = 0;
  localparam int M_ZERO = 1;
  localparam int M_ONE  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, start_a, mbit_a, en_a, lock_a, fault_a;
  logic signed [9:0] ph_a;
  logic [8:0]        ones_a;
  logic              rst_b, start_b, mbit_b, en_b, lock_b, fault_b;
  logic signed [9:0] ph_b;
  logic [8:0]        ones_b;

  dcm_phase_scheduler_if ifa ();
  dcm_phase_scheduler_if ifb ();

  dcm_phase_scheduler u_dut (
    .clk             (clk),
    .rst             (rst_a),
    .start           (start_a),
    .metastable_bit  (mbit_a),
    .ps              (ifa),
    .enable_sampling (en_a),
    .locked          (lock_a),
    .fault           (fault_a),
    .phase_pos       (ph_a),
    .ones_count      (ones_a)
  );

  dcm_phase_scheduler #(.MAX_STEPS(4)) u_sweep (
    .clk             (clk),
    .rst             (rst_b),
    .start           (start_b),
    .metastable_bit  (mbit_b),
    .ps              (ifb),
    .enable_sampling (en_b),
    .locked          (lock_b),
    .fault           (fault_b),
    .phase_pos       (ph_b),
    .ones_count      (ones_b)
  );

  int total = 0;
  int bad   = 0;
  int psen_cnt_a, psen_cnt_b, dly_a, dly_b, mode_a, mode_b, last_ph_b;
  bit resp_en_a, resp_en_b;
  int ph_log[$];
  int dir_log[$];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic next_bit(input int m, input logic cur);
    case (m)
      M_TOG:   return ~cur;
      M_ONE:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: sample at the falling edge, model the DCM (psdone 3 cycles
  // after psen) and drive the sampler bit for the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (ifa.psen === 1'b1) psen_cnt_a++;
    ifa.psdone = 1'b0;
    if (dly_a > 0) begin
      dly_a--;
      if (dly_a == 0) ifa.psdone = 1'b1;
    end
    if (ifa.psen === 1'b1 && resp_en_a) dly_a = 3;
    mbit_a = next_bit(mode_a, mbit_a);

    if (ifb.psen === 1'b1) begin
      psen_cnt_b++;
      dir_log.push_back(int'(ifb.psincdec));
    end
    if (int'(ph_b) != last_ph_b) begin
      last_ph_b = int'(ph_b);
      ph_log.push_back(last_ph_b);
    end
    ifb.psdone = 1'b0;
    if (dly_b > 0) begin
      dly_b--;
      if (dly_b == 0) ifb.psdone = 1'b1;
    end
    if (ifb.psen === 1'b1 && resp_en_b) dly_b = 3;
    mbit_b = next_bit(mode_b, mbit_b);
  endtask

  initial begin
    int k;
    int exp_ph[12];
    exp_ph = '{1, 2, 3, 4, 3, 2, 1, 0, -1, -2, -3, -4};

    rst_a = 1'b0; start_a = 1'b1; mbit_a = 1'b0; mode_a = M_TOG;
    resp_en_a = 1'b1; dly_a = 0; psen_cnt_a = 0; ifa.psdone = 1'b0;
    rst_b = 1'b0; start_b = 1'b0; mbit_b = 1'b0; mode_b = M_ZERO;
    resp_en_b = 1'b1; dly_b = 0; psen_cnt_b = 0; ifb.psdone = 1'b0;
    last_ph_b = 0;

    // Reset held 3 cycles with start asserted.
    repeat (3) tick();
    chk("rst_psen", ifa.psen, 0);
    chk("rst_psincdec", ifa.psincdec, 1);
    chk("rst_enable", en_a, 0);
    chk("rst_locked", lock_a, 0);
    chk("rst_fault", fault_a, 0);
    chk("rst_phase", ph_a, 0);
    chk("rst_ones", ones_a, 0);
    chk("rst_psen_count", psen_cnt_a, 0);

    // Immediate lock with a toggling sampler.
    rst_a = 1'b1;
    tick(); k = 0;
    chk("psen_after_release", ifa.psen, 1);
    start_a = 1'b0;
    tick(); k = 1;
    chk("psen_single_cycle", ifa.psen, 0);
    while (lock_a !== 1'b1 && k < 2000) begin tick(); k++; end
    chk("lock_latency", k, 325);
    chk("lock_enable", en_a, 1);
    chk("lock_phase", ph_a, 1);
    chk("lock_ones", ones_a, 128);
    chk("lock_psincdec", ifa.psincdec, 1);
    chk("lock_psen_count", psen_cnt_a, 1);

    // One bad window then a good one: stays locked.
    mode_a = M_ONE;
    while (k < 581) begin tick(); k++; end
    chk("miss1_ones", ones_a, 256);
    chk("miss1_locked", lock_a, 1);
    mode_a = M_TOG;
    while (k < 837) begin tick(); k++; end
    chk("recover_ones", ones_a, 128);
    chk("recover_locked", lock_a, 1);
    chk("recover_enable", en_a, 1);
    chk("recover_psen_count", psen_cnt_a, 1);

    // Two consecutive bad windows: lock drops and a shift follows.
    mode_a = M_ONE;
    while (k < 1093) begin tick(); k++; end
    chk("miss2a_ones", ones_a, 256);
    chk("miss2a_locked", lock_a, 1);
    while (k < 1348) begin tick(); k++; end
    chk("miss2b_pre_locked", lock_a, 1);
    tick(); k++;
    chk("relock_locked", lock_a, 0);
    chk("relock_enable", en_a, 0);
    chk("relock_psen", ifa.psen, 1);
    chk("relock_psen_count", psen_cnt_a, 2);
    chk("relock_psincdec", ifa.psincdec, 1);
    chk("relock_ones", ones_a, 256);

    // Stepping: five all-zero windows, then a toggling one.
    rst_a = 1'b0; start_a = 1'b1; mode_a = M_ZERO;
    repeat (2) tick();
    dly_a = 0; psen_cnt_a = 0; ifa.psdone = 1'b0;
    rst_a = 1'b1; k = 0;
    while (lock_a !== 1'b1 && k < 5000) begin
      tick(); k++;
      if (psen_cnt_a == 6) mode_a = M_TOG;
    end
    chk("step_psen_count", psen_cnt_a, 6);
    chk("step_phase", ph_a, 6);
    chk("step_locked", lock_a, 1);
    chk("step_enable", en_a, 1);
    chk("step_ones", ones_a, 128);
    chk("step_psincdec", ifa.psincdec, 1);

    // psdone never returns: timeout fault.
    rst_a = 1'b0; start_a = 1'b1; resp_en_a = 1'b0;
    repeat (2) tick();
    dly_a = 0; psen_cnt_a = 0; ifa.psdone = 1'b0;
    rst_a = 1'b1;
    tick(); k = 0;
    start_a = 1'b0;
    chk("to_psen", ifa.psen, 1);
    while (fault_a !== 1'b1 && k < 3000) begin tick(); k++; end
    chk("to_latency", k, 1024);
    chk("to_locked", lock_a, 0);
    chk("to_enable", en_a, 0);
    resp_en_a = 1'b1; start_a = 1'b1;
    repeat (50) tick();
    chk("to_fault_sticky", fault_a, 1);
    chk("to_psen_count", psen_cnt_a, 1);
    chk("to_psen_low", ifa.psen, 0);
    chk("to_phase", ph_a, 0);

    // Sweep exhaustion with MAX_STEPS=4 and a stuck-low sampler.
    start_b = 1'b1; rst_b = 1'b1; k = 0;
    while (fault_b !== 1'b1 && k < 8000) begin tick(); k++; end
    chk("sweep_fault", fault_b, 1);
    chk("sweep_psen_count", psen_cnt_b, 12);
    chk("sweep_phase", ph_b, -4);
    chk("sweep_psincdec", ifb.psincdec, 0);
    chk("sweep_locked", lock_b, 0);
    chk("sweep_enable", en_b, 0);
    chk("sweep_ones", ones_b, 0);
    chk("sweep_log_len", ph_log.size(), 12);
    for (int i = 0; i < ph_log.size() && i < 12; i++) begin
      chk($sformatf("sweep_phase_step%0d", i), ph_log[i], exp_ph[i]);
    end
    for (int i = 0; i < dir_log.size() && i < 12; i++) begin
      chk($sformatf("sweep_dir_step%0d", i), dir_log[i], (i < 4) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
